// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one regfile write port and one read port among N_MST requesters.
// One transaction at a time (IDLE -> EXEC -> RESP), with an optional bounded lock for atomic sequences.
module regfile_access_arbiter #(
    parameter int N_MST    = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_MST-1:0]        m_req_valid,
    output logic [N_MST-1:0]        m_req_ready,
    input  logic [N_MST-1:0]        m_req_write,
    input  logic [N_MST-1:0]        m_req_lock,
    input  logic [N_MST*ADDR_W-1:0] m_req_addr,
    input  logic [N_MST*DATA_W-1:0] m_req_wdata,
    input  logic [N_MST*BE_W-1:0]   m_req_be,
    output logic [N_MST-1:0]        m_rsp_valid,
    output logic [DATA_W-1:0]       m_rsp_rdata,
    output logic                    rf_wr_en,
    output logic [ADDR_W-1:0]       rf_wr_addr,
    output logic [DATA_W-1:0]       rf_wr_data,
    output logic [BE_W-1:0]         rf_wr_be,
    output logic [ADDR_W-1:0]       rf_rd_addr,
    input  logic [DATA_W-1:0]       rf_rd_data,
    output logic                    busy
);

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam logic [N_MST-1:0] ONE = {{(N_MST-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] lock_owner;
    logic             lock_active;
    logic [3:0]       lock_cnt;

    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic [DATA_W-1:0] rsp_rdata;

    logic [N_MST-1:0] eligible;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             hs;

    // Handshake: m_req_ready[i] is asserted only in IDLE, only for the round-robin
    // winner, independent of anything but registered state and m_req_valid; a
    // request is taken on the rising edge where valid[i] & ready[i] are both high.
    always_comb begin
        eligible  = lock_active ? (m_req_valid & (ONE << lock_owner)) : m_req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        // Scan farthest-first so the candidate nearest last_grant+1 overwrites the rest.
        for (int k = N_MST; k >= 1; k--) begin
            int c;
            c = int'(last_grant) + k;
            if (c >= N_MST) c = c - N_MST;
            if (eligible[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    assign hs          = (state == ST_IDLE) && win_found;
    assign m_req_ready = hs ? (ONE << win_idx) : '0;
    assign m_rsp_valid = (state == ST_RESP) ? (ONE << grant_idx) : '0;
    assign m_rsp_rdata = rsp_rdata;
    assign busy        = (state != ST_IDLE);

    assign rf_wr_en   = (state == ST_EXEC) && cmd_write;
    assign rf_wr_addr = cmd_addr;
    assign rf_wr_data = cmd_wdata;
    assign rf_wr_be   = cmd_be;
    assign rf_rd_addr = cmd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_W'(N_MST - 1);
            grant_idx   <= '0;
            lock_owner  <= '0;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_be      <= '0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        cmd_write  <= m_req_write[win_idx];
                        cmd_addr   <= m_req_addr[win_idx*ADDR_W +: ADDR_W];
                        cmd_wdata  <= m_req_wdata[win_idx*DATA_W +: DATA_W];
                        cmd_be     <= m_req_be[win_idx*BE_W +: BE_W];
                        grant_idx  <= win_idx;
                        last_grant <= win_idx;
                        // The cap forces release on the LOCK_MAX-th consecutive locked grant.
                        if (m_req_lock[win_idx] && (lock_cnt < 4'(LOCK_MAX - 1))) begin
                            lock_active <= 1'b1;
                            lock_owner  <= win_idx;
                            lock_cnt    <= lock_cnt + 4'd1;
                        end else begin
                            lock_active <= 1'b0;
                            lock_cnt    <= '0;
                        end
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_rdata <= cmd_write ? '0 : rf_rd_data;
                    state     <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: latency, round-robin order, lock, lock cap, reset.
module tb_regfile_access_arbiter;

    localparam int N = 3;
    localparam int A = 8;
    localparam int D = 32;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   m_req_valid, m_req_ready, m_req_write, m_req_lock, m_rsp_valid;
    logic [N*A-1:0] m_req_addr;
    logic [N*D-1:0] m_req_wdata;
    logic [N*B-1:0] m_req_be;
    logic [D-1:0]   m_rsp_rdata, rf_wr_data, rf_rd_data;
    logic           rf_wr_en, busy;
    logic [A-1:0]   rf_wr_addr, rf_rd_addr;
    logic [B-1:0]   rf_wr_be;

    int total = 0;
    int bad   = 0;

    regfile_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_write(m_req_write), .m_req_lock(m_req_lock),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_wr_be(rf_wr_be), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int oh2idx(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        m_req_valid = '0; m_req_write = '0; m_req_lock = '0;
        m_req_addr  = '0; m_req_wdata = '0; m_req_be = '0;
        rf_rd_data  = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic lk,
                           input logic [A-1:0] addr, input logic [D-1:0] wd);
        m_req_valid[i]        = 1'b1;
        m_req_write[i]        = wr;
        m_req_lock[i]         = lk;
        m_req_addr[i*A +: A]  = addr;
        m_req_wdata[i*D +: D] = wd;
        m_req_be[i*B +: B]    = 4'hF;
    endtask

    // Leaves the caller at a falling edge with reset just released and the DUT idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        total++; if (m_rsp_valid !== 3'b000) begin bad++; $display("FAIL reset_rsp_valid: got %0h expected 0", m_rsp_valid); end
        total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0h expected 0", rf_wr_en); end
        total++; if (m_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %0h expected 0", m_rsp_rdata); end
        total++; if (rf_wr_addr !== 8'h0 || rf_rd_addr !== 8'h0) begin bad++; $display("FAIL reset_addr: got wr=%0h rd=%0h expected 0", rf_wr_addr, rf_rd_addr); end
        total++; if (m_req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %0h expected 0", m_req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h00, 32'hDEADBEEF);
        #1;
        total++; if (m_req_ready !== 3'b001) begin bad++; $display("FAIL wr_ready: got %0h expected 1", m_req_ready); end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL wr_en_exec: got %0h expected 1", rf_wr_en); end
        total++; if (rf_wr_addr !== 8'h00 || rf_wr_data !== 32'hDEADBEEF || rf_wr_be !== 4'hF) begin
            bad++; $display("FAIL wr_fields: got addr=%0h data=%0h be=%0h expected 0/deadbeef/f", rf_wr_addr, rf_wr_data, rf_wr_be); end
        total++; if (busy !== 1'b1 || m_req_ready !== 3'b000) begin bad++; $display("FAIL wr_exec_busy: got busy=%0h ready=%0h expected 1/0", busy, m_req_ready); end
        @(negedge clk);
        #1;
        total++; if (m_rsp_valid !== 3'b001) begin bad++; $display("FAIL wr_rsp_valid: got %0h expected 1", m_rsp_valid); end
        total++; if (m_rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_rdata: got %0h expected 0", m_rsp_rdata); end
        total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL wr_en_resp: got %0h expected 0", rf_wr_en); end
        @(negedge clk);
        #1;
        total++; if (m_rsp_valid !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL wr_idle: got rsp=%0h busy=%0h expected 0/0", m_rsp_valid, busy); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(1, 1'b0, 1'b0, 8'h04, 32'h0);
        rf_rd_data = 32'h00010000;
        #1;
        total++; if (m_req_ready !== 3'b010) begin bad++; $display("FAIL rd_ready: got %0h expected 2", m_req_ready); end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        total++; if (rf_wr_en !== 1'b0 || rf_rd_addr !== 8'h04) begin bad++; $display("FAIL rd_exec: got wr_en=%0h rd_addr=%0h expected 0/4", rf_wr_en, rf_rd_addr); end
        @(negedge clk);
        rf_rd_data = 32'hFFFFFFFF;
        #1;
        total++; if (m_rsp_valid !== 3'b010) begin bad++; $display("FAIL rd_rsp_valid: got %0h expected 2", m_rsp_valid); end
        total++; if (m_rsp_rdata !== 32'h00010000) begin bad++; $display("FAIL rd_rsp_rdata: got %0h expected 10000", m_rsp_rdata); end
        total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rd_no_write: got %0h expected 0", rf_wr_en); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0] exp_q[$];
        int last_c = -1;
        int idx;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h1000);
        set_req(1, 1'b1, 1'b0, 8'h11, 32'h1001);
        set_req(2, 1'b1, 1'b0, 8'h12, 32'h1002);
        for (int c = 0; c < 14; c++) begin
            #1;
            total++; if ($countones(m_req_ready) > 1) begin bad++; $display("FAIL cont_onehot: got %0h expected at most one bit", m_req_ready); end
            if (m_req_ready !== 3'b000) begin
                idx = oh2idx(m_req_ready);
                if (last_c >= 0) begin
                    total++; if (c - last_c != 3) begin bad++; $display("FAIL cont_spacing: got %0d expected 3", c - last_c); end
                end
                last_c = c;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL cont_extra_grant: got %0d expected none", idx); end
                else if (idx != int'(exp_q[0])) begin bad++; $display("FAIL cont_order: got %0d expected %0d", idx, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_missing: got %0d left expected 0", exp_q.size()); end
        m_req_valid = '0;
    endtask

    task automatic test_lock();
        logic [1:0] exp_q[$];
        int g = 0;
        int idx;
        exp_q = '{2'd2, 2'd2, 2'd0, 2'd1};
        do_reset();
        // Make m1 the last grant so m2 is next in round-robin order.
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        m_req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 8'h30, 32'hA0);
        set_req(1, 1'b1, 1'b0, 8'h31, 32'hA1);
        for (int c = 0; c < 10; c++) begin
            if (g == 0) set_req(2, 1'b0, 1'b1, 8'h40, 32'h0);
            else if (g == 1) set_req(2, 1'b1, 1'b0, 8'h40, 32'h0000_0004);
            else m_req_valid[2] = 1'b0;
            #1;
            if (m_req_ready !== 3'b000) begin
                idx = oh2idx(m_req_ready);
                g++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL lock_extra_grant: got %0d expected none", idx); end
                else if (idx != int'(exp_q[0])) begin bad++; $display("FAIL lock_order: got %0d expected %0d", idx, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lock_missing: got %0d left expected 0", exp_q.size()); end
        m_req_valid = '0;
    endtask

    task automatic test_lock_cap();
        logic [1:0] exp_q[$];
        int g = 0;
        int idx;
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
        do_reset();
        set_req(1, 1'b0, 1'b1, 8'h50, 32'h0);
        for (int c = 0; c < 16; c++) begin
            if (g >= 1) set_req(0, 1'b1, 1'b0, 8'h51, 32'hB0);
            #1;
            if (m_req_ready !== 3'b000) begin
                idx = oh2idx(m_req_ready);
                g++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL cap_extra_grant: got %0d expected none", idx); end
                else if (idx != int'(exp_q[0])) begin bad++; $display("FAIL cap_order: got %0d expected %0d", idx, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cap_missing: got %0d left expected 0", exp_q.size()); end
        m_req_valid = '0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_req(1, 1'b1, 1'b0, 8'h60, 32'h12345678);
        #1;
        total++; if (m_req_ready !== 3'b010) begin bad++; $display("FAIL mid_ready: got %0h expected 2", m_req_ready); end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL mid_exec_wr: got %0h expected 1", rf_wr_en); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rf_wr_en !== 1'b0 || m_rsp_valid !== 3'b000) begin
            bad++; $display("FAIL mid_async: got busy=%0h wr_en=%0h rsp=%0h expected 0", busy, rf_wr_en, m_rsp_valid); end
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || rf_wr_en !== 1'b0 || m_rsp_valid !== 3'b000) begin
            bad++; $display("FAIL mid_next: got busy=%0h wr_en=%0h rsp=%0h expected 0", busy, rf_wr_en, m_rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h70, 32'h0);
        set_req(1, 1'b0, 1'b0, 8'h71, 32'h0);
        set_req(2, 1'b0, 1'b0, 8'h72, 32'h0);
        #1;
        total++; if (m_req_ready !== 3'b001) begin bad++; $display("FAIL mid_first_grant: got %0h expected 1", m_req_ready); end
        @(negedge clk);
        m_req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_lock();
        test_lock_cap();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
